// File: rtl/btop_pkg.sv
// Shared types and constants for the beta-top partial-sum storage controller.
// Slot geometry is derived from the code length N and the PE parallelism P.
// The quantisation width only affects the storage datapath, not this controller.
package btop_pkg;

  localparam int N        = 1024;
  localparam int P        = 64;
  localparam int WR_SLOTS = N / (4 * P);
  localparam int RD_SLOTS = 2 * WR_SLOTS;
  localparam int WR_W     = $clog2(WR_SLOTS);
  localparam int RD_W     = $clog2(RD_SLOTS);
  localparam int CNT_W    = RD_W + 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE      = 2'd1,
    S_READ       = 2'd2,
    S_WR_PREEMPT = 2'd3
  } state_t;

  // Slot index of beat 'off' in a burst starting at 'base', wrapped to 'slots'.
  function automatic int unsigned slot_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned slots);
    return (base + off) % slots;
  endfunction

endpackage

// File: rtl/btop_burst_cnt.sv
// Burst sequencer: captures start slot and length on load, counts issued beats,
// and presents the current wrapped slot plus a last-beat flag. The beat counter
// holds whenever 'beat' is low, which lets the caller freeze a burst mid-way.
module btop_burst_cnt
  import btop_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int W     = $clog2(SLOTS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] start,
  input  logic [W-1:0] len_m1,
  input  logic         beat,
  output logic [W-1:0] slot,
  output logic         last
);

  logic [W-1:0] start_q;
  logic [W-1:0] len_q;
  logic [W-1:0] idx_q;

  // Burst parameters and beat index; load restarts the burst, beat advances it.
  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values and block ordering cannot create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else if (load) begin
      start_q <= start;
      len_q   <= len_m1;
      idx_q   <= '0;
    end else if (beat) begin
      idx_q   <= idx_q + 1'b1;
    end
  end

  assign slot = W'(slot_wrap(32'(start_q), 32'(idx_q), SLOTS));
  assign last = (idx_q == len_q);

endmodule

// File: rtl/ram_btop_ctrl.sv
// Sequencer/arbiter for the beta-top partial-sum storage of the SCAN decoder.
// Writes win over reads in IDLE; reads produce rd_valid one cycle after r_en to
// line up with the storage's registered read port.
// Optional build macro: BTOP_HAZARD_CHK_EN -- tracks per-slot validity, stalls
// reads of not-yet-written slots and lets a write preempt a stalled read.
module ram_btop_ctrl
  import btop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_clr,
  input  logic             wr_req,
  input  logic [WR_W-1:0]  wr_start,
  input  logic [WR_W-1:0]  wr_len_m1,
  output logic             wr_ack,
  output logic             wr_done,
  input  logic             rd_req,
  input  logic [RD_W-1:0]  rd_start,
  input  logic [RD_W-1:0]  rd_len_m1,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic             rd_done,
  output logic             w_en,
  output logic [CNT_W-1:0] cnta,
  output logic             r_en,
  output logic [CNT_W-1:0] cntb,
  output logic             busy
);

  state_t          state_q, state_d;
  logic            wr_load, rd_load;
  logic [WR_W-1:0] wr_slot;
  logic [RD_W-1:0] rd_slot;
  logic            wr_last, rd_last;
  logic            rd_valid_q, rd_done_q;
  logic            rd_stall;

  btop_burst_cnt #(.SLOTS(WR_SLOTS)) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (wr_load),
    .start  (wr_start),
    .len_m1 (wr_len_m1),
    .beat   (w_en),
    .slot   (wr_slot),
    .last   (wr_last)
  );

  btop_burst_cnt #(.SLOTS(RD_SLOTS)) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (rd_load),
    .start  (rd_start),
    .len_m1 (rd_len_m1),
    .beat   (r_en),
    .slot   (rd_slot),
    .last   (rd_last)
  );

`ifdef BTOP_HAZARD_CHK_EN
  logic [RD_SLOTS-1:0] slot_valid;
  logic [WR_SLOTS-1:0] wr_half;

  // One-hot of the slot being written; it maps onto both halves of the read space.
  always_comb begin
    wr_half          = '0;
    wr_half[wr_slot] = w_en;
  end

  // Slot validity: frame_clr wipes, a write beat sets; a coinciding write wins.
  // NOTE: rst is sampled only at the clock edge; this small flag vector must be
  // reset (unlike a data RAM) because reads are gated on it.
  always_ff @(posedge clk) begin
    if (rst) slot_valid <= '0;
    else     slot_valid <= (frame_clr ? '0 : slot_valid) | {wr_half, wr_half};
  end

  assign rd_stall = ~slot_valid[rd_slot];
`else
  logic unused_frame_clr;
  assign unused_frame_clr = frame_clr;
  assign rd_stall         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, arbitration and beat strobes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wr_ack  = 1'b0;
    rd_ack  = 1'b0;
    wr_load = 1'b0;
    rd_load = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    wr_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          wr_ack  = 1'b1;
          wr_load = 1'b1;
          state_d = S_WRITE;
        end else if (rd_req) begin
          rd_ack  = 1'b1;
          rd_load = 1'b1;
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        w_en = 1'b1;
        if (wr_last) begin
          wr_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_stall) begin
`ifdef BTOP_HAZARD_CHK_EN
          // Read pointer stays frozen; let the missing data be written now.
          if (wr_req) begin
            wr_ack  = 1'b1;
            wr_load = 1'b1;
            state_d = S_WR_PREEMPT;
          end
`endif
        end else begin
          r_en = 1'b1;
          if (rd_last) state_d = S_IDLE;
        end
      end
`ifdef BTOP_HAZARD_CHK_EN
      S_WR_PREEMPT: begin
        w_en = 1'b1;
        if (wr_last) begin
          wr_done = 1'b1;
          state_d = S_READ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Read-data strobe pipeline matching the storage's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      rd_valid_q <= r_en;
      rd_done_q  <= r_en & rd_last;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign cnta     = w_en ? CNT_W'(wr_slot) : '0;
  assign cntb     = r_en ? CNT_W'(rd_slot) : '0;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_btop_ctrl.sv
// Self-checking bench for ram_btop_ctrl. Expected write/read beats are queued
// when a request is driven and retired as the DUT issues w_en / r_en.
// Hazard-specific checks are compiled in with BTOP_HAZARD_CHK_EN.
module tb_ram_btop_ctrl;
  import btop_pkg::*;

  logic             clk = 1'b0;
  logic             rst, frame_clr;
  logic             wr_req, rd_req;
  logic [WR_W-1:0]  wr_start, wr_len_m1;
  logic [RD_W-1:0]  rd_start, rd_len_m1;
  logic             wr_ack, wr_done, rd_ack, rd_valid, rd_done;
  logic             w_en, r_en, busy;
  logic [CNT_W-1:0] cnta, cntb;

  typedef struct {
    int slot;
    bit last;
  } beat_t;

  beat_t wr_q[$];
  beat_t rd_q[$];
  bit    exp_valid_nxt = 1'b0;
  bit    exp_done_nxt  = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  ram_btop_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_clr (frame_clr),
    .wr_req    (wr_req),
    .wr_start  (wr_start),
    .wr_len_m1 (wr_len_m1),
    .wr_ack    (wr_ack),
    .wr_done   (wr_done),
    .rd_req    (rd_req),
    .rd_start  (rd_start),
    .rd_len_m1 (rd_len_m1),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_done   (rd_done),
    .w_en      (w_en),
    .cnta      (cnta),
    .r_en      (r_en),
    .cntb      (cntb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the input-drive window just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample: retire scoreboard entries against the DUT strobes.
  task automatic chk();
    beat_t e;
    @(negedge clk);
    check("rd_valid", 32'(rd_valid), 32'(exp_valid_nxt));
    check("rd_done",  32'(rd_done),  32'(exp_done_nxt));
    exp_valid_nxt = 1'b0;
    exp_done_nxt  = 1'b0;
    if (w_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(w_en), 0);
      else begin
        e = wr_q.pop_front();
        check("cnta",    32'(cnta),    e.slot);
        check("wr_done", 32'(wr_done), 32'(e.last));
      end
    end
    if (r_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'(r_en), 0);
      else begin
        e = rd_q.pop_front();
        check("cntb", 32'(cntb), e.slot);
        exp_valid_nxt = 1'b1;
        exp_done_nxt  = e.last;
      end
    end
  endtask

  task automatic push_wr(input int start, input int len_m1);
    for (int i = 0; i <= len_m1; i++)
      wr_q.push_back('{slot: (start + i) % WR_SLOTS, last: (i == len_m1)});
  endtask

  task automatic push_rd(input int start, input int len_m1);
    for (int i = 0; i <= len_m1; i++)
      rd_q.push_back('{slot: (start + i) % RD_SLOTS, last: (i == len_m1)});
  endtask

  // Run until all queued beats retire and the DUT is idle; requesters drop on ack.
  task automatic run_until_idle(input int max_cycles);
    bit drained = 1'b0;
    bit drop_wr, drop_rd;
    for (int i = 0; i < max_cycles && !drained; i++) begin
      chk();
      drop_wr = wr_ack;
      drop_rd = rd_ack;
      if (wr_q.size() == 0 && rd_q.size() == 0 && !exp_valid_nxt && !busy &&
          !wr_req && !rd_req)
        drained = 1'b1;
      step();
      if (drop_wr) wr_req = 1'b0;
      if (drop_rd) rd_req = 1'b0;
    end
    check("drain_timeout", 32'(drained), 1);
  endtask

  initial begin
    rst       = 1'b1;
    frame_clr = 1'b0;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    wr_start  = '0;
    wr_len_m1 = '0;
    rd_start  = '0;
    rd_len_m1 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    check("rst_busy",     32'(busy),     0);
    check("rst_w_en",     32'(w_en),     0);
    check("rst_r_en",     32'(r_en),     0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_cnta",     32'(cnta),     0);
    check("rst_cntb",     32'(cntb),     0);
    check("rst_wr_ack",   32'(wr_ack),   0);
    step();

    // Simultaneous write (slots 0..3) and read (slots 6,7,0,1): write wins.
    rst       = 1'b0;
    wr_req    = 1'b1;
    wr_start  = 2'd0;
    wr_len_m1 = 2'd3;
    rd_req    = 1'b1;
    rd_start  = 3'd6;
    rd_len_m1 = 3'd3;
    push_wr(0, 3);
    push_rd(6, 3);
    chk();
    check("arb_wr_ack", 32'(wr_ack), 1);
    check("arb_rd_ack", 32'(rd_ack), 0);
    check("arb_busy",   32'(busy),   0);
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk();
      check("wr_busy",      32'(busy),   1);
      check("wr_rd_ack",    32'(rd_ack), 0);
      check("wr_beat_w_en", 32'(w_en),   1);
      step();
    end
    chk();
    check("rd_ack_after_wr", 32'(rd_ack), 1);
    check("idle_busy",       32'(busy),   0);
    step();
    rd_req = 1'b0;
    run_until_idle(20);

    // Wrap-around write: slots 3 then 0 after a frame clear.
    frame_clr = 1'b1;
    chk();
    step();
    frame_clr = 1'b0;
`ifdef BTOP_HAZARD_CHK_EN
    check("clr_slot_valid", 32'(dut.slot_valid), 0);
`endif
    wr_req    = 1'b1;
    wr_start  = 2'd3;
    wr_len_m1 = 2'd1;
    push_wr(3, 1);
    run_until_idle(20);
`ifdef BTOP_HAZARD_CHK_EN
    check("wrap_slot_valid", 32'(dut.slot_valid), 32'h99);
`endif

    // Hazard: only slot 0 written, read 0..1, then write slot 1 during the read.
    frame_clr = 1'b1;
    chk();
    step();
    frame_clr = 1'b0;
    wr_req    = 1'b1;
    wr_start  = 2'd0;
    wr_len_m1 = 2'd0;
    push_wr(0, 0);
    run_until_idle(20);
    rd_req    = 1'b1;
    rd_start  = 3'd0;
    rd_len_m1 = 3'd1;
    push_rd(0, 1);
    chk();
    check("hz_rd_ack", 32'(rd_ack), 1);
    step();
    rd_req = 1'b0;
    chk();
    step();
    chk();
`ifdef BTOP_HAZARD_CHK_EN
    check("hz_stall_r_en", 32'(r_en), 0);
    check("hz_stall_busy", 32'(busy), 1);
`endif
    step();
    wr_req    = 1'b1;
    wr_start  = 2'd1;
    wr_len_m1 = 2'd0;
    push_wr(1, 0);
    run_until_idle(30);

    // Reset in the middle of a read burst.
    rd_req    = 1'b1;
    rd_start  = 3'd0;
    rd_len_m1 = 3'd1;
    push_rd(0, 1);
    chk();
    check("mr_rd_ack", 32'(rd_ack), 1);
    step();
    rd_req = 1'b0;
    rst    = 1'b1;
    chk();
    check("mr_first_r_en", 32'(r_en), 1);
    step();
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    exp_valid_nxt = 1'b0;
    exp_done_nxt  = 1'b0;
    chk();
    check("mr_r_en",     32'(r_en),     0);
    check("mr_rd_valid", 32'(rd_valid), 0);
    check("mr_rd_done",  32'(rd_done),  0);
    check("mr_busy",     32'(busy),     0);
    step();

    check("wr_q_empty", 32'(wr_q.size()), 0);
    check("rd_q_empty", 32'(rd_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
